// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants, channel names and helpers for the perf counter bank
package perf_pkg;

    localparam int PERF_SEL_W   = 4;
    localparam int PERF_MAX_CNT = 16;

    // Conventional channel assignment used by software
    typedef enum logic [1:0] {
        CYC      = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_MISS = 2'd2,
        USER     = 2'd3
    } perf_ch_e;

    // True when a read select addresses an implemented channel
    function automatic logic sel_valid(input logic [PERF_SEL_W-1:0] sel, input int num_cnt);
        return 32'(sel) < num_cnt;
    endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - read port bundle for the perf counter bank
interface perf_counter_bank_if #(
    parameter int CNT_W = 64
);
    import perf_pkg::*;

    logic [PERF_SEL_W-1:0] rd_sel;
    logic                  rd_shadow;
    logic [CNT_W-1:0]      rd_data;

    modport master (output rd_sel, output rd_shadow, input rd_data);
    modport slave  (input rd_sel, input rd_shadow, output rd_data);

endinterface

// File: rtl/perf_counter_cell.sv
// rtl/perf_counter_cell.sv - one event counter with shadow copy and sticky overflow (PERF_SATURATE_EN selects saturate vs wrap)
module perf_counter_cell #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic             snap,
    output logic [CNT_W-1:0] live_o,
    output logic [CNT_W-1:0] shadow_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             ovf_q, ovf_d;

    // Next state: snapshot takes the pre-update value, clear beats increment
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        shd_d = snap ? cnt_q : shd_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == ALL_ONES) begin
                ovf_d = 1'b1;
`ifdef PERF_SATURATE_EN
                cnt_d = ALL_ONES;
`else
                cnt_d = '0;
`endif
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // State registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            shd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            shd_q <= shd_d;
            ovf_q <= ovf_d;
        end
    end

    assign live_o   = cnt_q;
    assign shadow_o = shd_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters with PC dedup, snapshot and registered read (PERF_SATURATE_EN selects saturate vs wrap)
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 64,
    parameter int PC_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic [NUM_CNT-1:0]  event_vec,
    input  logic [NUM_CNT-1:0]  dedup_mask,
    input  logic [PC_W-1:0]     pc,
    input  logic                snap,
    perf_counter_bank_if.slave  rd,
    output logic [NUM_CNT-1:0]  ovf
);

    logic [PC_W-1:0]    pc_old_q;
    logic               pc_chg;
    logic [NUM_CNT-1:0] inc;

    // Padded to the maximum channel count so any 4-bit select indexes safely
    logic [CNT_W-1:0]   live_w   [PERF_MAX_CNT];
    logic [CNT_W-1:0]   shadow_w [PERF_MAX_CNT];

    logic [CNT_W-1:0]   rd_data_q, rd_data_d;

    // Track the previous PC every cycle, independent of enable and events
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_old_q <= '0;
        end else begin
            pc_old_q <= pc;
        end
    end

    assign pc_chg = (pc != pc_old_q);
    assign inc    = {NUM_CNT{enable}} & event_vec & (~dedup_mask | {NUM_CNT{pc_chg}});

    generate
        for (genvar gi = 0; gi < PERF_MAX_CNT; gi++) begin : g_ch
            if (gi < NUM_CNT) begin : g_cell
                perf_counter_cell #(.CNT_W(CNT_W)) u_cell (
                    .clk      (clk),
                    .rst      (rst),
                    .clear    (clear),
                    .inc      (inc[gi]),
                    .snap     (snap),
                    .live_o   (live_w[gi]),
                    .shadow_o (shadow_w[gi]),
                    .ovf_o    (ovf[gi])
                );
            end else begin : g_empty
                assign live_w[gi]   = '0;
                assign shadow_w[gi] = '0;
            end
        end
    endgenerate

    // Read mux sees pre-update values, so a read racing an increment returns the old count
    always_comb begin
        rd_data_d = '0;
        if (sel_valid(rd.rd_sel, NUM_CNT)) begin
            rd_data_d = rd.rd_shadow ? shadow_w[rd.rd_sel] : live_w[rd.rd_sel];
        end
    end

    // Registered read data, one cycle behind the select
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd.rd_data = rd_data_q;

endmodule
